// File: rtl/booth_pkg.sv
// Shared constants for the radix-2 Booth multiplier: operand width, counter
// width and the strobe bit positions used by both the control unit and datapath.
package booth_pkg;

  localparam int W_DEF     = 32;
  localparam int CW_DEF    = $clog2(W_DEF);
  localparam int N_STROBES = 7;

  localparam int C0_IDX = 0;  // load
  localparam int C1_IDX = 1;  // decode marker
  localparam int C2_IDX = 2;  // accumulate
  localparam int C3_IDX = 3;  // subtract select
  localparam int C4_IDX = 4;  // shift
  localparam int C5_IDX = 5;  // drive high word
  localparam int C6_IDX = 6;  // drive low word

  typedef logic [N_STROBES-1:0] strobe_t;

endpackage

// File: rtl/booth_counter.sv
// Iteration counter for the Booth datapath: clears on load, counts shifts and
// flags the final iteration so the control unit can leave its loop.
module booth_counter
  import booth_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          count31
);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  // Clear has priority; increment wraps modulo 2^CW.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr)
      cnt_next = '0;
    else if (inc)
      cnt_next = cnt_reg + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end

  assign cnt     = cnt_reg;
  assign count31 = (cnt_reg == CW'(W - 1));

endmodule

// File: rtl/booth_datapath.sv
// Radix-2 Booth multiplier datapath: A/Q/M registers, Q-1 bit, add/subtract
// adder, iteration counter and registered output bus, steered by strobes c0-c6.
module booth_datapath
  import booth_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         c0,
  input  logic         c1,
  input  logic         c2,
  input  logic         c3,
  input  logic         c4,
  input  logic         c5,
  input  logic         c6,
  input  logic [W-1:0] inbus_m,
  input  logic [W-1:0] inbus_q,
  output logic         q0,
  output logic         q_1,
  output logic         count31,
  output logic [W-1:0] outbus,
  output logic         out_valid
);

  strobe_t strobes;
  assign strobes = {c6, c5, c4, c3, c2, c1, c0};

  // The decode marker carries no register effect in this datapath.
  logic unused_c1;
  assign unused_c1 = strobes[C1_IDX];

  logic [W:0]   a_reg, a_next;
  logic [W-1:0] q_reg, q_next;
  logic [W-1:0] m_reg, m_next;
  logic         q_m1_reg, q_m1_next;
  logic [W-1:0] outbus_reg, outbus_next;
  logic         out_valid_reg;

  logic         do_load, do_acc, do_shift;
  logic [W:0]   m_ext;
  logic [W:0]   acc_sum;
  logic [CW-1:0] cnt_unused;

  assign do_load  = strobes[C0_IDX];
  assign do_acc   = strobes[C2_IDX] & ~do_load;
  assign do_shift = strobes[C4_IDX] & ~do_load & ~strobes[C2_IDX];

  // The guard bit keeps A - M exact when M is the most negative operand.
  assign m_ext   = {m_reg[W-1], m_reg};
  assign acc_sum = strobes[C3_IDX] ? (a_reg - m_ext) : (a_reg + m_ext);

  always_comb begin
    a_next    = a_reg;
    q_next    = q_reg;
    m_next    = m_reg;
    q_m1_next = q_m1_reg;
    if (do_load) begin
      a_next    = '0;
      q_next    = inbus_q;
      m_next    = inbus_m;
      q_m1_next = 1'b0;
    end else if (do_acc) begin
      a_next = acc_sum;
    end else if (do_shift) begin
      a_next    = {a_reg[W], a_reg[W:1]};
      q_next    = {a_reg[0], q_reg[W-1:1]};
      q_m1_next = q_reg[0];
    end
  end

  // Low word wins when both output strobes are raised together.
  always_comb begin
    outbus_next = outbus_reg;
    if (strobes[C6_IDX])
      outbus_next = q_reg;
    else if (strobes[C5_IDX])
      outbus_next = a_reg[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg         <= '0;
      q_reg         <= '0;
      m_reg         <= '0;
      q_m1_reg      <= 1'b0;
      outbus_reg    <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      a_reg         <= a_next;
      q_reg         <= q_next;
      m_reg         <= m_next;
      q_m1_reg      <= q_m1_next;
      outbus_reg    <= outbus_next;
      out_valid_reg <= strobes[C5_IDX] | strobes[C6_IDX];
    end
  end

  booth_counter #(
    .W  (W),
    .CW (CW)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .clr     (do_load),
    .inc     (do_shift),
    .cnt     (cnt_unused),
    .count31 (count31)
  );

  assign q0        = q_reg[0];
  assign q_1       = q_m1_reg;
  assign outbus    = outbus_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_booth_datapath.sv
// Self-checking bench for booth_datapath: plays the control unit's role and
// compares results against a plain signed-multiply reference.
module tb_booth_datapath;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         c0, c1, c2, c3, c4, c5, c6;
  logic [W-1:0] inbus_m, inbus_q;
  logic         q0, q_1, count31, out_valid;
  logic [W-1:0] outbus;

  int checks   = 0;
  int failures = 0;

  booth_datapath #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .c0        (c0),
    .c1        (c1),
    .c2        (c2),
    .c3        (c3),
    .c4        (c4),
    .c5        (c5),
    .c6        (c6),
    .inbus_m   (inbus_m),
    .inbus_q   (inbus_q),
    .q0        (q0),
    .q_1       (q_1),
    .count31   (count31),
    .outbus    (outbus),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] S_C0 = 7'b0000001;
  localparam logic [6:0] S_C1 = 7'b0000010;
  localparam logic [6:0] S_C2 = 7'b0000100;
  localparam logic [6:0] S_C3 = 7'b0001000;
  localparam logic [6:0] S_C4 = 7'b0010000;
  localparam logic [6:0] S_C5 = 7'b0100000;
  localparam logic [6:0] S_C6 = 7'b1000000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock with the given strobes; outputs are settled on return.
  task automatic cyc(input logic [6:0] s);
    {c6, c5, c4, c3, c2, c1, c0} = s;
    @(posedge clk);
    #1;
    {c6, c5, c4, c3, c2, c1, c0} = '0;
  endtask

  task automatic run_mult(input logic [W-1:0] m, input logic [W-1:0] q);
    longint      p;
    logic [63:0] pv;
    int          errs0;
    errs0 = failures;
    p  = longint'($signed(m)) * longint'($signed(q));
    pv = p;
    inbus_m = m;
    inbus_q = q;
    cyc(S_C0);
    for (int i = 0; i < W; i++) begin
      cyc(S_C1);
      check("count31_loop", count31, (i == W - 1));
      if ({q0, q_1} == 2'b10)
        cyc(S_C2 | S_C3);
      else if ({q0, q_1} == 2'b01)
        cyc(S_C2);
      cyc(S_C4);
    end
    check("count31_after", count31, 1'b0);
    cyc(S_C5);
    check("prod_hi", outbus, pv[63:32]);
    check("valid_hi", out_valid, 1'b1);
    cyc(S_C6);
    check("prod_lo", outbus, pv[31:0]);
    check("valid_lo", out_valid, 1'b1);
    cyc('0);
    check("valid_idle", out_valid, 1'b0);
    check("outbus_hold", outbus, pv[31:0]);
    $display("mult m=%h q=%h product=%h errors=%0d", m, q, pv, failures - errs0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] qv;
    rst = 1'b1;
    {c6, c5, c4, c3, c2, c1, c0} = '0;
    inbus_m = '0;
    inbus_q = '0;
    #3;
    check("rst_outbus", outbus, 0);
    check("rst_valid", out_valid, 0);
    check("rst_q0", q0, 0);
    check("rst_q_1", q_1, 0);
    check("rst_count31", count31, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    run_mult(32'd3, 32'd5);
    run_mult(-32'sd7, 32'd6);
    run_mult(32'h8000_0000, 32'h8000_0000);
    run_mult(32'h7FFF_FFFF, 32'h8000_0000);
    for (int k = 0; k < 8; k++)
      run_mult($urandom, $urandom);

    // Lone shifts after load: Q shifts down with zeros since A stays 0.
    inbus_m = 32'h1234_5678;
    inbus_q = $urandom | 32'h1;
    qv = {32'h0, inbus_q};
    cyc(S_C0);
    for (int i = 0; i < W; i++) begin
      check("shift_count31", count31, (i == W - 1));
      check("shift_q0", q0, qv[i]);
      cyc(S_C4);
    end
    check("wrap_count31", count31, 0);
    check("wrap_q0", q0, 0);
    check("wrap_q_1", q_1, qv[W-1]);
    cyc(S_C1);
    check("c1_q0", q0, 0);
    check("c1_q_1", q_1, qv[W-1]);
    check("c1_count31", count31, 0);
    check("c1_valid", out_valid, 0);
    for (int i = 0; i < W - 1; i++) cyc(S_C4);
    check("rewrap_count31", count31, 1);
    $display("shift walk q=%h errors=%0d", inbus_q, failures);

    // Load wins over shift when both are strobed with A nonzero.
    inbus_m = 32'd9;
    inbus_q = 32'h0000_0003;
    cyc(S_C0);
    cyc(S_C2);
    cyc(S_C4);
    inbus_q = 32'h0000_00A5;
    cyc(S_C0 | S_C4);
    check("ld_shift_count31", count31, 0);
    check("ld_shift_q0", q0, 1);
    check("ld_shift_q_1", q_1, 0);
    cyc(S_C5);
    check("ld_shift_A", outbus, 0);
    cyc(S_C5 | S_C6);
    check("c5c6_outbus", outbus, 32'h0000_00A5);
    check("c5c6_valid", out_valid, 1);
    // c3 without c2 leaves A untouched.
    cyc(S_C3);
    cyc(S_C5);
    check("c3_alone_A", outbus, 0);
    $display("load priority errors=%0d", failures);

    // Asynchronous reset mid-multiply with A and Q populated.
    inbus_m = 32'd5;
    inbus_q = 32'h1234_5679;
    cyc(S_C0);
    cyc(S_C6);
    cyc(S_C2 | S_C3);
    cyc(S_C4);
    cyc(S_C4);
    #2 rst = 1'b1;
    #1;
    check("midrst_outbus", outbus, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_q0", q0, 0);
    check("midrst_q_1", q_1, 0);
    check("midrst_count31", count31, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(S_C5);
    check("postrst_A", outbus, 0);
    cyc(S_C6);
    check("postrst_Q", outbus, 0);
    run_mult(-32'sd100, 32'd37);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_datapath.md
# booth_datapath

Register/arithmetic datapath for the radix-2 Booth signed multiplier, directly downstream of the Booth control unit. Consumes the unit's one-hot-ish control strobes c0–c6 and returns the status bits q0, q_1 and count31 that steer its state machine. Holds the A/Q/M registers, the Q₋₁ bit, the add/subtract adder, the iteration counter and the registered output bus.

## Interface
- W, 32, operand width; product is 2·W bits
- CW, $clog2(W), iteration counter width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- c0  in  1  load: M←inbus_m, Q←inbus_q, A←0, Q₋₁←0, cnt←0
- c1  in  1  decode-phase marker; no register effect
- c2  in  1  accumulate: A←A±M
- c3  in  1  with c2: select subtract (A−M); ignored without c2
- c4  in  1  arithmetic right shift {A,Q,Q₋₁}, cnt←cnt+1
- c5  in  1  outbus←A[W-1:0] (product high word)
- c6  in  1  outbus←Q (product low word)
- inbus_m  in  W  multiplicand, signed
- inbus_q  in  W  multiplier, signed
- q0  out  1  Q[0], combinational from register
- q_1  out  1  Q₋₁, combinational from register
- count31  out  1  high when cnt == W-1
- outbus  out  W  registered result word
- out_valid  out  1  registered; high the cycle after any c5 or c6 edge

## Operation
- A is W+1 bits (sign guard); M sign-extended to W+1 for the adder; prevents overflow at M = −2^(W−1).
- Per clock, priority: c0 > c2 > c4. c0 alone touches A/Q/M/Q₋₁/cnt; c2 and c4 are mutually exclusive in register effect, the higher one wins.
- c2: A←A+Mext (c3=0) or A−Mext (c3=1), W+1-bit two's-complement, result truncated to W+1 bits.
- c4: A←{A[W],A[W:1]}, Q←{A[0],Q[W-1:1]}, Q₋₁←Q[0]; cnt increments modulo 2^CW (W-1 wraps to 0).
- c5/c6 are independent of the arithmetic strobes; if both high, c6 wins. outbus holds its value otherwise.
- out_valid ← c5 | c6 each cycle.
- c1 and any combination with no active strobe: all registers hold.
- After exactly W c4 pulses following c0, {A[W-1:0],Q} is the signed 2W-bit product.

## Timing
- Reset: A, Q, M, Q₋₁, cnt, outbus = 0; out_valid = 0; hence q0 = 0, q_1 = 0, count31 = 0.
- Strobes are sampled at the rising edge; inbus_m/inbus_q must be stable in the cycle c0 is high.
- q0/q_1/count31 reflect register state with zero added latency (valid the cycle after the updating edge) so the control unit's decode state sees post-shift Q.
- count31 is high during the W-th c4 cycle; that shift still executes, then cnt wraps to 0.
- Multiply latency from c0 edge: 2 or 3 cycles per iteration × W, plus one cycle each for c5, c6; out_valid trails each by one cycle.
- rst mid-operation: immediate clear of all state; the next c0 starts a fresh multiply, no residue.
- c0 arriving mid-multiply: aborts and reloads, cnt cleared.

## Structure
- Shared package booth_pkg: W default, CW, strobe-index constants for c0–c6, widths shared with the control unit.
- One sub-module: booth_counter (CW-bit counter, clear on c0, increment on c4, terminal flag = count31).
- Adder/shifter stay inline.

## Test plan
- Reset asserted mid-run, A/Q populated → outputs all 0 same cycle, count31 = 0, out_valid = 0.
- inbus_m=3, inbus_q=5, full control sequence → c5 outbus=0x00000000, c6 outbus=0x0000000F, out_valid one cycle after each.
- inbus_m=−7, inbus_q=6 → high 0xFFFFFFFF, low 0xFFFFFFD6.
- inbus_m=inbus_q=0x80000000 → high 0x40000000, low 0x00000000 (guard-bit check).
- c0 then 32 lone c4 pulses → count31 high only during pulse 32, cnt=0 afterwards; c1 alone changes nothing.
- c0 and c4 in same cycle with A nonzero → load wins, A=0, cnt=0; c5 and c6 together → outbus=Q.
